shift_normalizer: RTL and testbench
===================================

SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, shift-amount width fixed at 5 bits.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_valid  input  1  upstream presents an operand.
REQ-005 o_ready  output  1  block accepts an operand this cycle.
REQ-006 i_signed  input  1  1 = two's-complement normalize, 0 = unsigned normalize; sampled with i_data.
REQ-007 i_data  input  32  operand to normalize.
REQ-008 o_valid  output  1  result presented downstream.
REQ-009 i_ready  input  1  downstream accepts result.
REQ-010 o_data  output  32  normalized operand (left-shifted).
REQ-011 o_shift_amt  output  5  left-shift distance applied; the amount a right shift restores.
REQ-012 o_zero  output  1  operand was 0 (no leading one or sign change found).

Function
REQ-013 Transfer in occurs when i_valid && o_ready; transfer out when o_valid && i_ready.
REQ-014 Unsigned: o_shift_amt = count of leading zeros of i_data (0..31); o_data = i_data << o_shift_amt, zero-filled.
REQ-015 Signed: o_shift_amt = count of leading bits equal to i_data[31], minus 1 (0..31); o_data = i_data << o_shift_amt, zero-filled; o_data[31] equals i_data[31], o_data[30] differs from it unless the operand is -1.
REQ-016 Signed -1 (0xFFFFFFFF): o_shift_amt = 31, o_data = 0x80000000, o_zero = 0.
REQ-017 Operand 0 (either mode): o_zero = 1, o_shift_amt = 0, o_data = 0.
REQ-018 Pipeline: 2 register stages; stage 1 registers the operand, mode, leading count and zero flag; stage 2 registers the shifted result.
REQ-019 Latency: result presented on o_valid exactly 2 cycles after the transfer-in edge when not stalled.
REQ-020 Throughput: one operand per cycle while i_ready = 1.
REQ-021 Stage advance: stage 2 loads when empty or its output is consumed in the same cycle; stage 1 loads when empty or it advances into stage 2 in the same cycle; o_ready = !v1 || !v2 || i_ready.
REQ-022 Bubbles collapse: an empty stage 2 accepts from stage 1 even while i_ready = 0.
REQ-023 While o_valid && !i_ready, o_data, o_shift_amt and o_zero hold stable, and no operand is lost or duplicated.
REQ-024 Simultaneous transfer-in and transfer-out in one cycle, with both stages full, is legal and preserves order.
REQ-025 o_ready has no combinational path from i_valid; o_valid has no combinational path from any input.

Reset
REQ-026 On the i_clk edge with i_rst_n = 0: stage valid flags cleared, o_valid = 0, o_data = 0, o_shift_amt = 0, o_zero = 0.
REQ-027 Reset mid-operation discards all in-flight operands; first cycle after reset o_ready = 1.
REQ-028 Data registers other than the outputs need no reset.

Structure
REQ-029 The shared package shift_pkg holds DATA_W = 32, SHAMT_W = 5 and the shamt_t / data_t typedefs; the barrel shifter and this block both use it.
REQ-030 Leading-count logic is one combinational sub-module, lead_count (inputs data and signed; outputs count and zero), built as a 16/8/4/2/1 priority tree.
REQ-031 The stage-2 left shift is a log-structured mux (16/4-group/1-group), not a variable shift operator chain.

Verification
REQ-032 Unsigned 0x00000001 -> o_shift_amt = 31, o_data = 0x80000000, o_zero = 0, 2 cycles later.
REQ-033 Signed 0x00000001 -> 30, 0x40000000; signed 0xFFFF0000 -> 15, 0x80000000; signed 0xFFFFFFFF -> 31, 0x80000000.
REQ-034 0x00000000 in both modes -> o_zero = 1, amt 0, data 0; 0x80000000 unsigned -> amt 0, data 0x80000000.
REQ-035 Stream 8 back-to-back operands with i_ready held 0 for 5 cycles mid-stream -> o_ready drops after 2 held, outputs stable, all 8 results in order.
REQ-036 Assert i_rst_n = 0 with both stages full -> next cycle o_valid = 0, o_ready = 1; no stale result emerges afterward.
REQ-037 Random operands and modes -> scoreboard check that a right shift of o_data by o_shift_amt (arithmetic when signed) equals i_data.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared widths, types and the log-structured left shifter for the normalizer.
package shift_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

  // Three mux layers: by 16, by a multiple of 4 (0..12), then by 0..3.
  function automatic data_t shl_log(data_t d, shamt_t s);
    data_t a;
    data_t b;
    data_t c;
    a = s[4] ? {d[15:0], 16'h0} : d;
    case (s[3:2])
      2'd0:    b = a;
      2'd1:    b = {a[27:0], 4'h0};
      2'd2:    b = {a[23:0], 8'h0};
      default: b = {a[19:0], 12'h0};
    endcase
    case (s[1:0])
      2'd0:    c = b;
      2'd1:    c = {b[30:0], 1'b0};
      2'd2:    c = {b[29:0], 2'b0};
      default: c = {b[28:0], 3'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shift_normalizer_if.sv
// Operand-in / result-out handshake bundle of the shift normalizer.
interface shift_normalizer_if;
  import shift_pkg::*;

  logic   i_valid;
  logic   o_ready;
  logic   i_signed;
  data_t  i_data;
  logic   o_valid;
  logic   i_ready;
  data_t  o_data;
  shamt_t o_shift_amt;
  logic   o_zero;

  // Design side.
  modport slave (
    input  i_valid, i_signed, i_data, i_ready,
    output o_ready, o_valid, o_data, o_shift_amt, o_zero
  );

  // Stimulus side.
  modport master (
    output i_valid, i_signed, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_shift_amt, o_zero
  );

endinterface

// File: rtl/lead_count.sv
// Combinational leading-count: leading zeros (unsigned) or redundant sign bits (signed).
module lead_count
  import shift_pkg::*;
(
  input  data_t  data_i,
  input  logic   signed_i,
  output shamt_t count_o,
  output logic   zero_o
);

  data_t  src;
  data_t  v;
  shamt_t cnt;

  always_comb begin
    // Signed: zeros of (bits 30:0 xor sign), with a stop bit so -1 counts 31.
    src = signed_i ? {data_i[30:0] ^ {31{data_i[31]}}, 1'b1} : data_i;
    v   = src;
    cnt = '0;
    if (v[31:16] == 16'h0) begin
      cnt[4] = 1'b1;
      v      = {v[15:0], 16'h0};
    end
    if (v[31:24] == 8'h0) begin
      cnt[3] = 1'b1;
      v      = {v[23:0], 8'h0};
    end
    if (v[31:28] == 4'h0) begin
      cnt[2] = 1'b1;
      v      = {v[27:0], 4'h0};
    end
    if (v[31:30] == 2'b0) begin
      cnt[1] = 1'b1;
      v      = {v[29:0], 2'b0};
    end
    if (!v[31]) begin
      cnt[0] = 1'b1;
    end
    zero_o  = (data_i == '0);
    count_o = zero_o ? '0 : cnt;
  end

endmodule

// File: rtl/shift_normalizer.sv
// Two-stage normalizer: stage 1 holds operand and leading count, stage 2 the shifted result.
module shift_normalizer
  import shift_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  shift_normalizer_if.slave  bus
);

  logic   v1_q, v1_d;
  logic   v2_q, v2_d;
  data_t  data1_q;
  shamt_t cnt1_q;
  logic   zero1_q;
  data_t  odata_q, odata_d;
  shamt_t oamt_q, oamt_d;
  logic   ozero_q, ozero_d;

  shamt_t lc_count;
  logic   lc_zero;
  logic   load1;
  logic   load2;

  lead_count u_lead_count (
    .data_i   (bus.i_data),
    .signed_i (bus.i_signed),
    .count_o  (lc_count),
    .zero_o   (lc_zero)
  );

  assign load2       = !v2_q || bus.i_ready;
  assign load1       = !v1_q || load2;
  assign bus.o_ready = load1;
  assign bus.o_valid = v2_q;
  assign bus.o_data      = odata_q;
  assign bus.o_shift_amt = oamt_q;
  assign bus.o_zero      = ozero_q;

  always_comb begin
    v1_d    = v1_q;
    v2_d    = v2_q;
    odata_d = odata_q;
    oamt_d  = oamt_q;
    ozero_d = ozero_q;
    if (load1) begin
      v1_d = bus.i_valid;
    end
    if (load2) begin
      v2_d = v1_q;
      if (v1_q) begin
        odata_d = shl_log(data1_q, cnt1_q);
        oamt_d  = cnt1_q;
        ozero_d = zero1_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      odata_q <= '0;
      oamt_q  <= '0;
      ozero_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      odata_q <= odata_d;
      oamt_q  <= oamt_d;
      ozero_q <= ozero_d;
    end
  end

  // Stage-1 payload is qualified by v1_q, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (load1 && bus.i_valid) begin
      data1_q <= bus.i_data;
      cnt1_q  <= lc_count;
      zero1_q <= lc_zero;
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench: directed vectors, stall and reset scenarios, random stream vs. model.
module tb_shift_normalizer;
  import shift_pkg::*;

  typedef struct {
    data_t  d;
    logic   s;
    data_t  od;
    shamt_t amt;
    logic   z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_normalizer_if bus ();

  shift_normalizer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  exp_t   q[$];
  logic   prev_stall = 1'b0;
  data_t  prev_d;
  shamt_t prev_a;
  logic   prev_z;

  // Reference: count leading bits directly from the definition.
  function automatic exp_t model(data_t d, logic s);
    exp_t e;
    int   n;
    n = 0;
    if (!s) begin
      while (n < 32 && d[31-n] == 1'b0) n++;
    end else begin
      while (n < 32 && d[31-n] == d[31]) n++;
      n = n - 1;
    end
    e.d = d;
    e.s = s;
    if (d == 32'h0) begin
      e.amt = '0;
      e.od  = '0;
      e.z   = 1'b1;
    end else begin
      e.amt = shamt_t'(n);
      e.od  = d << n;
      e.z   = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, monitor at negedge, return sampled handshake state.
  task automatic cycle(input logic v, input logic s, input data_t d, input logic r,
                       output logic fired, output logic rdy);
    exp_t  e;
    data_t rs;
    bus.i_valid  = v;
    bus.i_signed = s;
    bus.i_data   = d;
    bus.i_ready  = r;
    @(negedge clk);
    fired = 1'b0;
    rdy   = bus.o_ready;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_data", bus.o_data, prev_d);
        check("stall_amt", 32'(bus.o_shift_amt), 32'(prev_a));
        check("stall_zero", 32'(bus.o_zero), 32'(prev_z));
      end
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 32'(bus.o_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("data", bus.o_data, e.od);
          check("amt", 32'(bus.o_shift_amt), 32'(e.amt));
          check("zero", 32'(bus.o_zero), 32'(e.z));
          rs = e.s ? data_t'($signed(bus.o_data) >>> bus.o_shift_amt)
                   : bus.o_data >> bus.o_shift_amt;
          check("unshift", rs, e.d);
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        q.push_back(model(d, s));
        fired = 1'b1;
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_d     = bus.o_data;
      prev_a     = bus.o_shift_amt;
      prev_z     = bus.o_zero;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic  f, rd;
    data_t dir_d[8];
    logic  dir_s[8];
    data_t ops[8];
    int    idx;
    data_t rd_d;
    logic  rd_s;
    int    sent;

    dir_d = '{32'h00000001, 32'h00000001, 32'hFFFF0000, 32'hFFFFFFFF,
              32'h00000000, 32'h00000000, 32'h80000000, 32'h00F0F000};
    dir_s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ops   = '{32'h00000010, 32'hFFFFFF00, 32'h12345678, 32'h00000000,
              32'h80000000, 32'h0000FFFF, 32'hFFFFFFFF, 32'h00000003};

    // Reset state
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, '0, 1'b1, f, rd);
    cycle(1'b0, 1'b0, '0, 1'b1, f, rd);
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_o_data", bus.o_data, 32'h0);
    check("rst_o_amt", 32'(bus.o_shift_amt), 32'd0);
    check("rst_o_zero", 32'(bus.o_zero), 32'd0);
    check("rst_o_ready", 32'(bus.o_ready), 32'd1);
    rst_n = 1'b1;

    // Latency: unsigned 1 appears two edges after the transfer-in edge
    cycle(1'b1, 1'b0, 32'h00000001, 1'b1, f, rd);
    check("lat_in_fired", 32'(f), 32'd1);
    check("lat_edge1_valid", 32'(bus.o_valid), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, f, rd);
    check("lat_edge2_valid", 32'(bus.o_valid), 32'd1);
    check("lat_data", bus.o_data, 32'h80000000);
    check("lat_amt", 32'(bus.o_shift_amt), 32'd31);
    check("lat_zero", 32'(bus.o_zero), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, f, rd);

    // Directed corner vectors, back to back
    idx = 0;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      cycle(1'b1, dir_s[idx], dir_d[idx], 1'b1, f, rd);
      if (f) idx++;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, f, rd);
    check("dir_all_sent", 32'(idx), 32'd8);
    check("dir_drained", 32'(q.size()), 32'd0);

    // Stream of 8 with a 5-cycle downstream stall
    idx = 0;
    for (int k = 0; k < 40 && (idx < 8 || q.size() > 0); k++) begin
      logic r;
      r = !(k >= 3 && k < 8);
      cycle(idx < 8, k[0], (idx < 8) ? ops[idx] : '0, r, f, rd);
      if (k >= 3 && k < 8) check("stall_o_ready", 32'(rd), 32'd0);
      if (f) idx++;
    end
    check("stream_all_sent", 32'(idx), 32'd8);
    check("stream_drained", 32'(q.size()), 32'd0);

    // Reset with both stages full
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h00000100 << i, 1'b0, f, rd);
    check("full_o_ready", 32'(bus.o_ready), 32'd0);
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, '0, 1'b0, f, rd);
    rst_n = 1'b1;
    q.delete();
    check("midrst_o_valid", 32'(bus.o_valid), 32'd0);
    check("midrst_o_ready", 32'(bus.o_ready), 32'd1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1, f, rd);

    // Random stream
    sent = 0;
    rd_d = $urandom >> $urandom_range(0, 31);
    rd_s = 1'(($urandom_range(0, 1)));
    for (int k = 0; k < 2000 && sent < 300; k++) begin
      cycle($urandom_range(0, 9) < 8, rd_s, rd_d, $urandom_range(0, 3) != 0, f, rd);
      if (f) begin
        sent++;
        case ($urandom_range(0, 9))
          0:       rd_d = 32'h0;
          1:       rd_d = 32'hFFFFFFFF;
          default: rd_d = $urandom >> $urandom_range(0, 31);
        endcase
        rd_s = 1'($urandom_range(0, 1));
        if (rd_s && $urandom_range(0, 1) == 1) rd_d = ~rd_d;
      end
    end
    check("rand_all_sent", 32'(sent), 32'd300);
    for (int k = 0; k < 50 && q.size() > 0; k++) cycle(1'b0, 1'b0, '0, 1'b1, f, rd);
    check("rand_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
